// File: rtl/reg_file_pkg.sv
// Package: reg_file_pkg
// Shared constants and helpers for the reg_file register bank.
// Optional feature macro: ZERO_REG_EN (word 0 hardwired to zero).

package reg_file_pkg;

    // Value every storage bit and read register takes on reset and on clear
    localparam logic RF_RST_VAL = 1'b0;

    // Number of 8-bit byte lanes in a word of the given width
    function automatic int lane_count(input int width);
        return width / 8;
    endfunction

    // Single-lane merge: take the new byte when its enable is set, else keep the old one
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/reg_file_wmerge.sv
// Module: reg_file_wmerge
// Combinational byte-lane merge of an old word with write data under byte enables.
// The result is both the value stored by a write and the value forwarded on a bypass read.

module reg_file_wmerge
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]             old_word,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [lane_count(DATA_W)-1:0] wbe,
    output logic [DATA_W-1:0]             new_word
);

    localparam int NB = lane_count(DATA_W);

    // One merge cell per byte lane
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign new_word[8*i +: 8] = byte_merge(old_word[8*i +: 8], wdata[8*i +: 8], wbe[i]);
    end

endmodule

// File: rtl/reg_file.sv
// Module: reg_file
// DEPTH x DATA_W register bank: one byte-enabled write port, two registered read
// ports with write-first bypass, and a one-cycle synchronous bulk clear.
// Optional feature macro: ZERO_REG_EN -- word 0 reads as zero, ignores writes and
// has no storage behind it.

module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CLR,
    input  logic                          WR,
    input  logic [ADDR_W-1:0]             WADDR,
    input  logic [DATA_W-1:0]             WDATA,
    input  logic [lane_count(DATA_W)-1:0] WBE,
    input  logic                          RE_A,
    input  logic [ADDR_W-1:0]             RADDR_A,
    output logic [DATA_W-1:0]             RDATA_A,
    input  logic                          RE_B,
    input  logic [ADDR_W-1:0]             RADDR_B,
    output logic [DATA_W-1:0]             RDATA_B
);

`ifdef ZERO_REG_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{RF_RST_VAL}};

    // Only words that really hold state are declared; a hardwired word 0 is simply absent
    logic [DATA_W-1:0] mem [FIRST:DEPTH-1];

    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_new;
    logic [DATA_W-1:0] rd_a_word;
    logic [DATA_W-1:0] rd_b_word;
    logic              wr_hit;
    logic              byp_a;
    logic              byp_b;

    // True when the address maps onto a real storage word
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) >= FIRST) && (int'(a) < DEPTH);
    endfunction

    // A write lands only when not overridden by clear and it targets real storage
    assign wr_hit = WR && !CLR && addr_ok(WADDR);
    assign byp_a  = wr_hit && (RADDR_A == WADDR);
    assign byp_b  = wr_hit && (RADDR_B == WADDR);

    // Fetch the current contents at the write and read addresses; missing words read as zero
    always_comb begin
        wr_old    = ZERO_WORD;
        rd_a_word = ZERO_WORD;
        rd_b_word = ZERO_WORD;
        if (addr_ok(WADDR)) begin
            wr_old = mem[WADDR];
        end
        if (addr_ok(RADDR_A)) begin
            rd_a_word = mem[RADDR_A];
        end
        if (addr_ok(RADDR_B)) begin
            rd_b_word = mem[RADDR_B];
        end
    end

    // The post-write word serves the store and both bypass paths, since a bypass always hits WADDR
    reg_file_wmerge #(
        .DATA_W (DATA_W)
    ) u_wmerge (
        .old_word (wr_old),
        .wdata    (WDATA),
        .wbe      (WBE),
        .new_word (wr_new)
    );

    // Storage update: clear beats write, and a write only touches its enabled bytes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = FIRST; i < DEPTH; i++) begin
                mem[i] <= ZERO_WORD;
            end
        end else if (CLR) begin
            for (int i = FIRST; i < DEPTH; i++) begin
                mem[i] <= ZERO_WORD;
            end
        end else if (wr_hit) begin
            mem[WADDR] <= wr_new;
        end
    end

    // Port A read register: holds when idle, zero under clear, forwards a same-cycle write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RDATA_A <= ZERO_WORD;
        end else if (RE_A) begin
            if (CLR) begin
                RDATA_A <= ZERO_WORD;
            end else if (byp_a) begin
                RDATA_A <= wr_new;
            end else begin
                RDATA_A <= rd_a_word;
            end
        end
    end

    // Port B read register: same behaviour as port A, fully independent
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RDATA_B <= ZERO_WORD;
        end else if (RE_B) begin
            if (CLR) begin
                RDATA_B <= ZERO_WORD;
            end else if (byp_b) begin
                RDATA_B <= wr_new;
            end else begin
                RDATA_B <= rd_b_word;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Testbench: tb_reg_file
// Table-driven vectors for reg_file with a queue of expected read data that is
// filled when a cycle is driven and drained after the clock edge.
// Honours ZERO_REG_EN when the bench is built with the same macro as the design.

module tb_reg_file;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

`ifdef ZERO_REG_EN
    localparam logic [15:0] ZVAL = 16'h0000;
`else
    localparam logic [15:0] ZVAL = 16'hCAFE;
`endif

    typedef struct {
        logic        clr;
        logic        wr;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  wbe;
        logic        re_a;
        logic [2:0]  raddr_a;
        logic        re_b;
        logic [2:0]  raddr_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic              CLK;
    logic              RST_N;
    logic              CLR;
    logic              WR;
    logic [ADDR_W-1:0] WADDR;
    logic [DATA_W-1:0] WDATA;
    logic [1:0]        WBE;
    logic              RE_A;
    logic [ADDR_W-1:0] RADDR_A;
    logic [DATA_W-1:0] RDATA_A;
    logic              RE_B;
    logic [ADDR_W-1:0] RADDR_B;
    logic [DATA_W-1:0] RDATA_B;

    exp_t scoreboard[$];
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[17];

    reg_file #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CLR     (CLR),
        .WR      (WR),
        .WADDR   (WADDR),
        .WDATA   (WDATA),
        .WBE     (WBE),
        .RE_A    (RE_A),
        .RADDR_A (RADDR_A),
        .RDATA_A (RDATA_A),
        .RE_B    (RE_B),
        .RADDR_B (RADDR_B),
        .RDATA_B (RDATA_B)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the sequence never reaches its summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic        clr,
        input logic        wr,
        input logic [2:0]  waddr,
        input logic [15:0] wdata,
        input logic [1:0]  wbe,
        input logic        re_a,
        input logic [2:0]  raddr_a,
        input logic        re_b,
        input logic [2:0]  raddr_b,
        input logic [15:0] exp_a,
        input logic [15:0] exp_b
    );
        vec_t v;
        v.clr     = clr;
        v.wr      = wr;
        v.waddr   = waddr;
        v.wdata   = wdata;
        v.wbe     = wbe;
        v.re_a    = re_a;
        v.raddr_a = raddr_a;
        v.re_b    = re_b;
        v.raddr_b = raddr_b;
        v.exp_a   = exp_a;
        v.exp_b   = exp_b;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        CLR     = 1'b0;
        WR      = 1'b0;
        WADDR   = '0;
        WDATA   = '0;
        WBE     = '0;
        RE_A    = 1'b0;
        RADDR_A = '0;
        RE_B    = 1'b0;
        RADDR_B = '0;
    endtask

    // Drive one cycle, queue its expected read data, and step just past the rising edge
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        CLR     = v.clr;
        WR      = v.wr;
        WADDR   = v.waddr;
        WDATA   = v.wdata;
        WBE     = v.wbe;
        RE_A    = v.re_a;
        RADDR_A = v.raddr_a;
        RE_B    = v.re_b;
        RADDR_B = v.raddr_b;
        e.a = v.exp_a;
        e.b = v.exp_b;
        scoreboard.push_back(e);
        @(posedge CLK);
        #1;
        idleInputs();
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got A=0x%h B=0x%h", name, RDATA_A, RDATA_B);
        end else begin
            e = scoreboard.pop_front();
            checkValue({name, ".A"}, RDATA_A, e.a);
            checkValue({name, ".B"}, RDATA_B, e.b);
        end
    endtask

    initial begin
        // Byte enables, bypass, hold and dual-port streaming, zero-word behaviour
        vecs[0]  = mk(0, 1, 3'd2, 16'h1234, 2'b11, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000);
        vecs[1]  = mk(0, 1, 3'd2, 16'hAB00, 2'b10, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'd2, 0, 3'd0, 16'hAB34, 16'h0000);
        vecs[3]  = mk(0, 1, 3'd5, 16'h00FF, 2'b11, 0, 3'd0, 0, 3'd0, 16'hAB34, 16'h0000);
        vecs[4]  = mk(0, 1, 3'd5, 16'h7700, 2'b10, 1, 3'd5, 1, 3'd5, 16'h77FF, 16'h77FF);
        vecs[5]  = mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'd5, 1, 3'd2, 16'h77FF, 16'hAB34);
        vecs[6]  = mk(0, 1, 3'd5, 16'h0011, 2'b01, 1, 3'd2, 1, 3'd5, 16'hAB34, 16'h7711);
        vecs[7]  = mk(0, 1, 3'd2, 16'hFFFF, 2'b00, 1, 3'd2, 0, 3'd0, 16'hAB34, 16'h7711);
        vecs[8]  = mk(0, 1, 3'd6, 16'h55AA, 2'b11, 0, 3'd0, 0, 3'd0, 16'hAB34, 16'h7711);
        vecs[9]  = mk(0, 1, 3'd7, 16'h7777, 2'b11, 1, 3'd6, 0, 3'd0, 16'h55AA, 16'h7711);
        vecs[10] = mk(0, 1, 3'd1, 16'h1111, 2'b11, 0, 3'd6, 1, 3'd2, 16'h55AA, 16'hAB34);
        vecs[11] = mk(0, 0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 1, 3'd5, 16'h55AA, 16'h7711);
        vecs[12] = mk(0, 0, 3'd0, 16'h0000, 2'b00, 0, 3'd1, 1, 3'd6, 16'h55AA, 16'h55AA);
        vecs[13] = mk(0, 0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 1, 3'd7, 16'h55AA, 16'h7777);
        vecs[14] = mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 1, 3'd3, 16'h1111, 16'h0000);
        vecs[15] = mk(0, 1, 3'd0, 16'hCAFE, 2'b11, 1, 3'd0, 0, 3'd0, ZVAL,     16'h0000);
        vecs[16] = mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'd0, 1, 3'd0, ZVAL,     ZVAL);

        // Power-up reset, asserted with a real falling edge
        idleInputs();
        RST_N = 1'b1;
        #1;
        RST_N = 1'b0;
        #2;
        checkValue("por_rdata_a", RDATA_A, 16'h0000);
        checkValue("por_rdata_b", RDATA_B, 16'h0000);
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b1;

        // Store a word, read it back on both ports
        applyStimulus(mk(0, 1, 3'd3, 16'hBEEF, 2'b11, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000));
        checkOutput("rst_write");
        applyStimulus(mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'd3, 1, 3'd3, 16'hBEEF, 16'hBEEF));
        checkOutput("rst_readback");

        // Mid-cycle reset pulse clears the read registers without waiting for a clock
        #1;
        RST_N = 1'b0;
        #1;
        checkValue("async_rst_a", RDATA_A, 16'h0000);
        checkValue("async_rst_b", RDATA_B, 16'h0000);
        #1;
        RST_N = 1'b1;
        applyStimulus(mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'd3, 1, 3'd3, 16'h0000, 16'h0000));
        checkOutput("rst_cleared_word");

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Fill every word, then clear while writing and reading in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mk(0, 1, 3'(i), 16'hFFFF, 2'b11, 0, 3'd0, 0, 3'd0, ZVAL, ZVAL));
            checkOutput($sformatf("fill%0d", i));
        end
        applyStimulus(mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'd1, 1, 3'd6, 16'hFFFF, 16'hFFFF));
        checkOutput("filled_probe");
        applyStimulus(mk(1, 1, 3'd1, 16'h1111, 2'b11, 1, 3'd1, 1, 3'd3, 16'h0000, 16'h0000));
        checkOutput("clr_priority");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mk(0, 0, 3'd0, 16'h0000, 2'b00, 1, 3'(i), 1, 3'(DEPTH - 1 - i), 16'h0000, 16'h0000));
            checkOutput($sformatf("post_clr%0d", i));
        end

        if (scoreboard.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
